// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: core/auxiliary requester ports and the RAM-side port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_err;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              a_err;

  logic              ram_wren;
  logic              ram_wread;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  a_req, a_we, a_addr, a_wdata,
    input  ram_q,
    output c_gnt, c_rvalid, c_rdata, c_err,
    output a_gnt, a_rvalid, a_rdata, a_err,
    output ram_wren, ram_wread, ram_addr, ram_data
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output a_req, a_we, a_addr, a_wdata,
    output ram_q,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    input  ram_wren, ram_wread, ram_addr, ram_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (core/auxiliary) single-access RAM arbiter, round-robin on ties.
// Define ARB_CORE_PRIORITY_EN for fixed core-first priority instead.
module ram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic          CLK,
  input  logic          RESET_N,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic              l_we;
  logic              l_aux;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] a_rdata_q;

  logic any_req;
  logic sel_aux;
  logic in_range;
  logic in_access;
  logic in_rdata;

  assign any_req  = bus.c_req | bus.a_req;
  assign in_range = {1'b0, l_addr} < DEPTH_C;

`ifdef ARB_CORE_PRIORITY_EN
  assign sel_aux = ~bus.c_req;
`else
  logic last_aux;

  // On a tie the port that was not granted last wins.
  assign sel_aux = bus.a_req & (~bus.c_req | ~last_aux);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_aux <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_aux <= sel_aux;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      l_we      <= 1'b0;
      l_aux     <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      c_rdata_q <= '0;
      a_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            l_aux   <= sel_aux;
            l_we    <= sel_aux ? bus.a_we    : bus.c_we;
            l_addr  <= sel_aux ? bus.a_addr  : bus.c_addr;
            l_wdata <= sel_aux ? bus.a_wdata : bus.c_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          state <= (in_range && !l_we) ? RDATA : IDLE;
        end
        RDATA: begin
          if (l_aux) a_rdata_q <= bus.ram_q;
          else       c_rdata_q <= bus.ram_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_access = (state == ACCESS);
    in_rdata  = (state == RDATA);

    bus.c_gnt     = in_access & ~l_aux;
    bus.a_gnt     = in_access &  l_aux;
    bus.c_err     = in_access & ~l_aux & ~in_range;
    bus.a_err     = in_access &  l_aux & ~in_range;
    bus.ram_wren  = in_access & in_range &  l_we;
    bus.ram_wread = in_access & in_range & ~l_we;
    bus.ram_addr  = l_addr;
    bus.ram_data  = l_wdata;

    // Read data passes straight through in RDATA, then holds in the per-port register.
    bus.c_rvalid  = in_rdata & ~l_aux;
    bus.a_rvalid  = in_rdata &  l_aux;
    bus.c_rdata   = (in_rdata & ~l_aux) ? bus.ram_q : c_rdata_q;
    bus.a_rdata   = (in_rdata &  l_aux) ? bus.ram_q : a_rdata_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;
`ifdef ARB_CORE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  // Behavioural RAM with one-cycle read latency
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (bus.ram_wren)  ram[bus.ram_addr] <= bus.ram_data;
    if (bus.ram_wread) bus.ram_q <= ram[bus.ram_addr];
  end

  typedef struct {
    bit            pend;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } trx_t;

  int            checks = 0;
  int            errors = 0;
  trx_t          p [2];          // 0 = core, 1 = aux
  logic [DW-1:0] exp_mem [1024];
  logic [DW-1:0] last_rd [2];
  int            last_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("strobe_exclusive", 64'(bus.ram_wren & bus.ram_wread), 64'd0);
  endtask

  task automatic drive();
    bus.c_req = p[0].pend; bus.c_we = p[0].we; bus.c_addr = p[0].addr; bus.c_wdata = p[0].wdata;
    bus.a_req = p[1].pend; bus.a_we = p[1].we; bus.a_addr = p[1].addr; bus.a_wdata = p[1].wdata;
  endtask

  task automatic new_trx(input int i, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    p[i].pend = 1'b1; p[i].we = we; p[i].addr = addr; p[i].wdata = d;
  endtask

  task automatic rand_trx(input int i);
    logic [AW-1:0] a;
    if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(DEPTH, 1023));
    else                           a = AW'($urandom_range(0, 15));
    new_trx(i, 1'($urandom_range(0, 1)), a, $urandom());
  endtask

  function automatic int pick();
    if (p[0].pend && p[1].pend) return PRIO ? 0 : 1 - last_w;
    return p[0].pend ? 0 : 1;
  endfunction

  task automatic check_quiet(input string ph);
    chk({ph, "/c_gnt"},    64'(bus.c_gnt),    64'd0);
    chk({ph, "/a_gnt"},    64'(bus.a_gnt),    64'd0);
    chk({ph, "/c_rvalid"}, 64'(bus.c_rvalid), 64'd0);
    chk({ph, "/a_rvalid"}, 64'(bus.a_rvalid), 64'd0);
    chk({ph, "/c_err"},    64'(bus.c_err),    64'd0);
    chk({ph, "/a_err"},    64'(bus.a_err),    64'd0);
    chk({ph, "/ram_wren"}, 64'(bus.ram_wren), 64'd0);
    chk({ph, "/ram_wread"},64'(bus.ram_wread),64'd0);
    chk({ph, "/c_rdata"},  64'(bus.c_rdata),  64'(last_rd[0]));
    chk({ph, "/a_rdata"},  64'(bus.a_rdata),  64'(last_rd[1]));
  endtask

  // late: 0 none, 1 random new request on the idle port, 2 forced aux-style write on it
  task automatic round(input int late);
    int            w;
    bit            inr, rd;
    logic [DW-1:0] e;
    drive();
    check_quiet("idle");
    if (!p[0].pend && !p[1].pend) begin
      tick();
      return;
    end
    w = pick();
    last_w = w;
    tick();
    inr = (int'(p[w].addr) < DEPTH);
    chk("c_gnt",     64'(bus.c_gnt),     64'(w == 0));
    chk("a_gnt",     64'(bus.a_gnt),     64'(w == 1));
    chk("c_err",     64'(bus.c_err),     64'(w == 0 && !inr));
    chk("a_err",     64'(bus.a_err),     64'(w == 1 && !inr));
    chk("ram_wren",  64'(bus.ram_wren),  64'(inr && p[w].we));
    chk("ram_wread", 64'(bus.ram_wread), 64'(inr && !p[w].we));
    chk("ram_addr",  64'(bus.ram_addr),  64'(p[w].addr));
    chk("acc_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    chk("acc_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    if (inr && p[w].we) begin
      chk("ram_data", 64'(bus.ram_data), 64'(p[w].wdata));
      exp_mem[p[w].addr] = p[w].wdata;
    end
    rd = inr && !p[w].we;
    e  = exp_mem[p[w].addr];
    p[w].pend = 1'b0;
    if (late == 1 && !p[1-w].pend && $urandom_range(0, 3) == 0) rand_trx(1 - w);
    if (late == 2 && !p[1-w].pend) new_trx(1 - w, 1'b1, 10'd7, 32'h1234_5678);
    drive();
    if (rd) begin
      tick();
      chk("c_rvalid", 64'(bus.c_rvalid), 64'(w == 0));
      chk("a_rvalid", 64'(bus.a_rvalid), 64'(w == 1));
      chk("c_rdata",  64'(bus.c_rdata),  64'(w == 0 ? e : last_rd[0]));
      chk("a_rdata",  64'(bus.a_rdata),  64'(w == 1 ? e : last_rd[1]));
      chk("rd_c_gnt", 64'(bus.c_gnt), 64'd0);
      chk("rd_a_gnt", 64'(bus.a_gnt), 64'd0);
      chk("rd_wread", 64'(bus.ram_wread), 64'd0);
      chk("rd_wren",  64'(bus.ram_wren),  64'd0);
      last_rd[w] = e;
    end
    tick();
  endtask

  task automatic flush();
    for (int k = 0; k < 4 && (p[0].pend || p[1].pend); k++) round(0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = '0;
      exp_mem[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      p[i].pend = 1'b0; p[i].we = 1'b0; p[i].addr = '0; p[i].wdata = '0;
      last_rd[i] = '0;
    end
    last_w = 1;
    drive();

    // Reset state
    repeat (3) tick();
    check_quiet("reset");
    chk("reset/ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("reset/ram_data", 64'(bus.ram_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Both ports reading, held: alternation (or core-only under priority)
    for (int k = 0; k < 4; k++) begin
      if (!p[0].pend) new_trx(0, 1'b0, AW'(k), '0);
      if (!p[1].pend) new_trx(1, 1'b0, AW'(k + 1), '0);
      round(0);
    end
    flush();

    // Aux read just past the valid range
    new_trx(1, 1'b0, 10'd1000, '0);
    round(0);
    check_quiet("post_err");

    // Core write then read back
    new_trx(0, 1'b1, 10'h005, 32'hDEAD_BEEF);
    round(0);
    new_trx(0, 1'b0, 10'h005, '0);
    round(0);
    chk("core_readback", 64'(bus.c_rdata), 64'h0000_0000_DEAD_BEEF);

    // Aux write appears while the core read is in flight
    new_trx(0, 1'b0, 10'h005, '0);
    round(2);
    round(0);
    chk("late_aux_written", 64'(ram[7]), 64'h0000_0000_1234_5678);

    // Reset during the data cycle of a core read
    new_trx(0, 1'b0, 10'h005, '0);
    drive();
    tick();
    p[0].pend = 1'b0;
    drive();
    tick();
    rst_n = 1'b0;
    #1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    last_w = 1;
    check_quiet("abort");
    chk("abort/ram_addr", 64'(bus.ram_addr), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_rvalid", 64'(bus.c_rvalid), 64'd0);
    end
    new_trx(0, 1'b0, 10'h003, '0);
    new_trx(1, 1'b0, 10'h004, '0);
    round(0);
    flush();

    // Randomized traffic
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        if (!p[i].pend && $urandom_range(0, 1) == 1) rand_trx(i);
      round(1);
    end
    flush();
    check_quiet("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
